mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Multi-cycle multiply/divide unit sitting beside the ALU in the EX stage.
//   Consumes the same two 32-bit operands (rs/rt) and produces the HI/LO
//   register pair for mult/multu/div/divu/mthi/mtlo. While busy is high,
//   the hazard unit stalls any instruction that reads HI/LO or starts the MDU.
// PARAMETERS
//   MULT_CYCLES  5   busy duration (cycles) for mult/multu; legal range 1..15
//   DIV_CYCLES   10  busy duration (cycles) for div/divu; legal range 1..15
// PORTS
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous reset, active low
//   A       in   32  operand 1 (rs); dividend for div/divu
//   B       in   32  operand 2 (rt); divisor for div/divu
//   MDOp    in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x no-op
//   start   in   1   request: A/B/MDOp are valid this cycle
//   busy    out  1   operation in flight
//   HI      out  32  HI register
//   LO      out  32  LO register
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): HI=0, LO=0, busy=0, cycle counter=0,
//     internal result registers=0. Any operation in flight is abandoned; no
//     HI/LO write occurs from it. Release is sampled at the next rising edge.
//   States: IDLE (busy=0) and RUN (busy=1). A down-counter gives the latency.
//   IDLE, start=1, MDOp in {mult,multu,div,divu}, at edge E0:
//     - Latch the product/quotient/remainder into pending_hi/pending_lo.
//     - Load the counter with N-1, where N = MULT_CYCLES or DIV_CYCLES.
//     - Go to RUN. busy=1 for exactly N cycles after E0.
//   RUN, at each edge: if counter!=0, decrement it. If counter==0, then
//     HI<=pending_hi, LO<=pending_lo, busy<=0, and go to IDLE.
//     So HI/LO change on the same edge (E0+N) that busy falls.
//   IDLE, start=1, MDOp=mthi: HI<=A at E0. MDOp=mtlo: LO<=A at E0.
//     Latency is 1 edge and busy stays 0.
//   IDLE, start=1, MDOp=11x: ignored; no state change.
//   start=1 while busy=1: ignored entirely. The upstream stall logic must
//     prevent this; the MDU does not queue requests.
//   HI/LO hold their value in all other cycles, including throughout RUN.
//     Reads of HI/LO during RUN return the old values.
//   Arithmetic:
//     mult:  {HI,LO} = $signed(A) * $signed(B), full 64-bit result.
//     multu: {HI,LO} = A * B, unsigned, 64-bit.
//     div:   LO = quotient, truncated toward zero; HI = remainder, which takes
//            the sign of the dividend (A).
//     divu:  LO = A / B, HI = A % B, unsigned.
//   Boundary cases:
//     B==0 (div or divu): LO=32'hFFFF_FFFF, HI=A. Same N-cycle latency, no trap.
//     div with A=32'h8000_0000 and B=32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
//     Counter values at the N=1 boundary: busy is high for a single cycle.
//   busy is a registered output; no combinational path from start to busy.
// TESTING
//   1. Reset: hold rst_n=0 mid-mult (2 cycles after start) -> HI=LO=0 and
//      busy=0 immediately; after release, HI/LO stay 0.
//   2. mult with A=32'hFFFF_FFFE (-2), B=3 -> busy high 5 cycles; then
//      HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA. multu with the same operands ->
//      HI=2, LO=32'hFFFF_FFFA.
//   3. div with A=-7, B=2 -> after 10 cycles LO=32'hFFFF_FFFD (-3),
//      HI=32'hFFFF_FFFF (-1). divu with A=7, B=2 -> LO=3, HI=1.
//   4. Divide by zero: divu A=32'h1234, B=0 -> LO=32'hFFFF_FFFF, HI=32'h1234.
//      Overflow: div 32'h8000_0000 / -1 -> LO=32'h8000_0000, HI=0.
//   5. start=1 with mthi (A=5) issued 2 cycles into a div run -> ignored;
//      final HI/LO equal the div result only.
//   6. mthi A=32'hAAAA_AAAA, then mtlo A=32'h5555_5555 on consecutive cycles
//      -> each takes effect next edge, busy stays 0; MDOp=3'b110 start -> no
//      change.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit producing the HI/LO register pair.
// Arithmetic is resolved in the start cycle and parked in pending registers.
// A down-counter then models the unit latency before HI/LO are committed.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Signed divide returning {remainder, quotient}; covers divide-by-zero and
  // the single overflowing case explicitly so no tool-specific result leaks.
  function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'h0000_0000) begin
      sdiv = {a, 32'hFFFF_FFFF};
    end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      sdiv = {32'h0000_0000, 32'h8000_0000};
    end else begin
      q    = $signed(a) / $signed(b);
      r    = $signed(a) % $signed(b);
      sdiv = {r, q};
    end
  endfunction

  // Unsigned divide returning {remainder, quotient}.
  function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0000_0000) begin
      udiv = {a, 32'hFFFF_FFFF};
    end else begin
      udiv = {a % b, a / b};
    end
  endfunction

  state_t      state_r, state_next_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic        busy_r, busy_next_s;
  logic [31:0] hi_r, hi_next_s;
  logic [31:0] lo_r, lo_next_s;
  logic [31:0] pend_hi_r, pend_hi_next_s;
  logic [31:0] pend_lo_r, pend_lo_next_s;
  logic [63:0] arith_s;

  // Select the 64-bit {HI,LO} result for the requested arithmetic op.
  always_comb begin
    arith_s = 64'h0;
    case (MDOp)
      OP_MULT:  arith_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      OP_MULTU: arith_s = {32'h0000_0000, A} * {32'h0000_0000, B};
      OP_DIV:   arith_s = sdiv(A, B);
      OP_DIVU:  arith_s = udiv(A, B);
      default:  arith_s = 64'h0;
    endcase
  end

  // Next-state and next-register logic for the IDLE/RUN controller.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    busy_next_s    = busy_r;
    hi_next_s      = hi_r;
    lo_next_s      = lo_r;
    pend_hi_next_s = pend_hi_r;
    pend_lo_next_s = pend_lo_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              pend_hi_next_s = arith_s[63:32];
              pend_lo_next_s = arith_s[31:0];
              cnt_next_s     = MULT_LOAD;
              state_next_s   = ST_RUN;
              busy_next_s    = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_next_s = arith_s[63:32];
              pend_lo_next_s = arith_s[31:0];
              cnt_next_s     = DIV_LOAD;
              state_next_s   = ST_RUN;
              busy_next_s    = 1'b1;
            end
            OP_MTHI: hi_next_s = A;
            OP_MTLO: lo_next_s = A;
            default: state_next_s = ST_IDLE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // New requests are ignored here; the pipeline stalls them upstream.
        if (cnt_r != 4'd0) begin
          cnt_next_s = cnt_r - 4'd1;
        end else begin
          hi_next_s    = pend_hi_r;
          lo_next_s    = pend_lo_r;
          busy_next_s  = 1'b0;
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        busy_next_s  = 1'b0;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State, counter, pending results and architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      busy_r    <= 1'b0;
      hi_r      <= 32'h0000_0000;
      lo_r      <= 32'h0000_0000;
      pend_hi_r <= 32'h0000_0000;
      pend_lo_r <= 32'h0000_0000;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      busy_r    <= busy_next_s;
      hi_r      <= hi_next_s;
      lo_r      <= lo_next_s;
      pend_hi_r <= pend_hi_next_s;
      pend_lo_r <= pend_lo_next_s;
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule
